// File: rtl/byte_scan_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : byte_scan_engine
//  Brief    : Serial bit scanner. Accepts one word per valid/ready handshake,
//             walks it LSB first at one bit per clock and reports popcount,
//             parity, highest set-bit index and an all-zero flag on a held
//             valid/ready result port.
//  Revision : 1.0 - initial release
// ============================================================================
module byte_scan_engine #(
    parameter  int DATA_W = 8,
    localparam int CNT_W  = $clog2(DATA_W + 1),
    localparam int IDX_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_ones,
    output logic              out_parity,
    output logic [IDX_W-1:0]  out_msb_idx,
    output logic              out_zero,
    output logic              busy
);

    // The bit index carries one spare bit so the final position never
    // aliases back to zero; the scan is terminated by comparison.
    localparam int                IDX_QW   = IDX_W + 1;
    localparam logic [IDX_QW-1:0] LAST_IDX = IDX_QW'(DATA_W - 1);
    localparam logic [IDX_QW-1:0] IDX_ONE  = IDX_QW'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   shift_q;
    logic [IDX_QW-1:0]   idx_q;
    logic [CNT_W-1:0]    ones_q;
    logic                parity_q;
    logic [IDX_W-1:0]    msb_q;
    logic                zero_q;
    logic                valid_q;
    logic                ready_q;
    logic                busy_q;

    logic                bit_d;
    logic [CNT_W-1:0]    ones_d;
    logic                parity_d;
    logic [IDX_W-1:0]    msb_d;
    logic                last_d;

    // Accumulator updates for the bit currently at the bottom of the shifter.
    always_comb begin
        bit_d    = shift_q[0];
        ones_d   = ones_q;
        parity_d = parity_q;
        msb_d    = msb_q;
        if (bit_d) begin
            ones_d   = ones_q + CNT_ONE;
            parity_d = ~parity_q;
            msb_d    = idx_q[IDX_W-1:0];
        end
        last_d = (idx_q == LAST_IDX);
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            ones_q   <= '0;
            parity_q <= 1'b0;
            msb_q    <= '0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else if (flush) begin
            // Abort wins over any handshake on the same edge.
            state_q  <= S_IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            ones_q   <= '0;
            parity_q <= 1'b0;
            msb_q    <= '0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        shift_q  <= in_data;
                        idx_q    <= '0;
                        ones_q   <= '0;
                        parity_q <= 1'b0;
                        msb_q    <= '0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    shift_q  <= shift_q >> 1;
                    idx_q    <= idx_q + IDX_ONE;
                    ones_q   <= ones_d;
                    parity_q <= parity_d;
                    msb_q    <= msb_d;
                    if (last_d) begin
                        zero_q  <= (ones_d == '0);
                        valid_q <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    // No overlap: in_ready only returns once back in IDLE.
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = ready_q;
    assign out_valid   = valid_q;
    assign out_ones    = ones_q;
    assign out_parity  = parity_q;
    assign out_msb_idx = msb_q;
    assign out_zero    = zero_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_scan_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_byte_scan_engine
//  Brief    : Scoreboard bench for byte_scan_engine: directed scenarios plus
//             randomized traffic against a behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_byte_scan_engine;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int IDX_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CNT_W-1:0]  out_ones;
    logic              out_parity;
    logic [IDX_W-1:0]  out_msb_idx;
    logic              out_zero;
    logic              busy;

    always #5 clk = ~clk;

    byte_scan_engine #(.DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ones    (out_ones),
        .out_parity  (out_parity),
        .out_msb_idx (out_msb_idx),
        .out_zero    (out_zero),
        .busy        (busy)
    );

    typedef struct {
        logic [CNT_W-1:0] ones;
        logic             par;
        logic [IDX_W-1:0] msb;
        logic             zero;
        int               acc_cyc;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic inflight = 1'b0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: count the ones, parity is the count's oddness, highest set
    // position found by walking the word.
    function automatic exp_t model(input logic [DATA_W-1:0] w, input int t);
        exp_t e;
        int   n = 0;
        e.msb = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (w[i]) begin
                n++;
                e.msb = IDX_W'(i);
            end
        end
        e.ones    = CNT_W'(n);
        e.par     = ((n % 2) == 1);
        e.zero    = (n == 0);
        e.acc_cyc = t;
        return e;
    endfunction

    // Stimulus tracker: models acceptance/abort and checks handshake status.
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            inflight = 1'b0;
            expq.delete();
        end else begin
            chk("busy", busy, inflight);
            chk("in_ready", in_ready, !inflight);
            if (flush) begin
                inflight = 1'b0;
                expq.delete();
            end else if (!inflight && in_valid) begin
                expq.push_back(model(in_data, cyc));
                inflight = 1'b1;
            end else if (inflight && out_valid && out_ready) begin
                inflight = 1'b0;
            end
        end
    end

    // Monitor: compares every presented result against the queue head.
    always begin
        exp_t e;
        @(negedge clk);
        if (rst_n && out_valid) begin
            if (expq.size() == 0) begin
                chk("out_valid_unexpected", out_valid, 0);
            end else begin
                e = expq[0];
                chk("out_ones", out_ones, e.ones);
                chk("out_parity", out_parity, e.par);
                chk("out_msb_idx", out_msb_idx, e.msb);
                chk("out_zero", out_zero, e.zero);
                if (!prev_v) chk("latency", cyc - e.acc_cyc, DATA_W + 1);
                if (out_ready && !flush) void'(expq.pop_front());
            end
        end
        prev_v = rst_n && out_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] w);
        int g = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!(in_ready && !flush) && g < 100) begin
            step();
            g++;
        end
        if (g >= 100) chk("send_timeout", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (in_ready !== 1'b1 && g < 100) begin
            step();
            g++;
        end
        if (g >= 100) chk("idle_timeout", in_ready, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_ones"}, out_ones, 0);
        chk({tag, "_parity"}, out_parity, 0);
        chk({tag, "_msb"}, out_msb_idx, 0);
        chk({tag, "_zero"}, out_zero, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic [DATA_W-1:0] words [3];
        int                t [3];
        int                g;

        step();
        step();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();

        // Mixed word, then the two extremes.
        send(8'b1011_0101); wait_idle();
        send(8'h00);        wait_idle();
        send(8'hFF);        wait_idle();

        // Backpressure with a second word waiting during DONE.
        out_ready = 1'b0;
        send(8'b0000_1011);
        in_valid = 1'b1;
        in_data  = 8'h80;
        repeat (DATA_W + 5) step();
        chk("held_out_valid", out_valid, 1);
        chk("held_in_ready", in_ready, 0);
        out_ready = 1'b1;
        g = 0;
        while (!in_ready && g < 50) begin step(); g++; end
        step();
        in_valid = 1'b0;
        wait_idle();

        // Back-to-back throughput.
        words[0] = 8'h12; words[1] = 8'hE7; words[2] = 8'h40;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = words[k];
            g = 0;
            while (!in_ready && g < 50) begin step(); g++; end
            t[k] = cyc;
            step();
        end
        in_valid = 1'b0;
        chk("b2b_period_1", t[1] - t[0], DATA_W + 2);
        chk("b2b_period_2", t[2] - t[1], DATA_W + 2);
        wait_idle();

        // Flush mid-scan.
        send(8'h3C);
        repeat (3) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_in_ready", in_ready, 1);
        chk("flush_out_valid", out_valid, 0);
        repeat (DATA_W + 2) step();

        // Flush beats a word offered on the same edge.
        in_valid = 1'b1; in_data = 8'hA5; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_prio_in_ready", in_ready, 1);
        chk("flush_prio_busy", busy, 0);

        // Flush beats out_ready in DONE.
        out_ready = 1'b0;
        send(8'h81);
        repeat (DATA_W + 1) step();
        out_ready = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_done_out_valid", out_valid, 0);
        repeat (3) step();

        // Reset mid-scan.
        send(8'hC3);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        step();
        step();
        rst_n = 1'b1;
        chk("post_reset_in_ready", in_ready, 1);
        step();
        send(8'h5A); wait_idle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = DATA_W'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 99) < 3);
            step();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        repeat (3) step();
        chk("queue_drained", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
